// File: rtl/decoder_pkg.sv
// Shared state encoding and constants for the registered/scanned decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_DIRECT = 2'd1,
        STATE_SCAN   = 2'd2
    } state_t;

    // Smallest number of cycles a line is held in scan mode.
    localparam int unsigned DWELL_MIN = 1;

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Down-counter that measures how long the current scan line is held.
// A load of 0 is treated as DWELL_MIN so each line lasts at least one cycle.
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] r_count;
    logic [DWELL_W-1:0] w_reload;

    // Clamp the requested dwell to the minimum hold time.
    always_comb begin
        w_reload = load_val;
        if (load_val < DWELL_W'(DWELL_MIN)) begin
            w_reload = DWELL_W'(DWELL_MIN);
        end
    end

    // Count down to zero and stop there; load restarts the hold period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_reload - DWELL_W'(1);
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign expire = (r_count == '0);

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct and scan modes.
// Scan mode walks the active line through all outputs, holding each for
// max(dwell,1) cycles. All outputs come straight from registers.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int unsigned IN      = 3,
    parameter  int unsigned DWELL_W = 8,
    localparam int unsigned OUT     = 1 << IN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mode,
    input  logic [IN-1:0]      in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT-1:0]     out,
    output logic [IN-1:0]      active_idx,
    output logic               wrap,
    output logic               busy
);

    state_t r_state;
    state_t w_next_state;

    logic [OUT-1:0] r_out;
    logic [IN-1:0]  r_idx;
    logic           r_wrap;
    logic           r_busy;

    logic [OUT-1:0] w_out_next;
    logic [IN-1:0]  w_idx_next;
    logic           w_wrap_next;
    logic           w_busy_next;

    logic [IN-1:0]  w_idx_step;
    logic           w_expire;
    logic           w_timer_load;
    logic           w_timer_clear;

    assign w_idx_step = r_idx + IN'(1);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_timer_clear),
        .load     (w_timer_load),
        .load_val (dwell),
        .expire   (w_expire)
    );

    // Mode selection every cycle; enable dominates mode.
    always_comb begin
        w_next_state = STATE_IDLE;
        if (enable) begin
            w_next_state = mode ? STATE_SCAN : STATE_DIRECT;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next output values, keyed on the state being entered so outputs
    // reflect the new state one cycle after the inputs that select it.
    always_comb begin
        w_out_next    = r_out;
        w_idx_next    = r_idx;
        w_wrap_next   = 1'b0;
        w_busy_next   = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_clear = 1'b1;
        case (w_next_state)
            STATE_IDLE: begin
                w_out_next = '0;
            end
            STATE_DIRECT: begin
                w_idx_next = in;
                w_out_next = OUT'(1) << in;
            end
            STATE_SCAN: begin
                w_busy_next   = 1'b1;
                w_timer_clear = 1'b0;
                if (r_state != STATE_SCAN) begin
                    w_idx_next   = in;
                    w_out_next   = OUT'(1) << in;
                    w_timer_load = 1'b1;
                end else if (w_expire) begin
                    w_idx_next   = w_idx_step;
                    w_out_next   = OUT'(1) << w_idx_step;
                    w_timer_load = 1'b1;
                    w_wrap_next  = (r_idx == '1);
                end
            end
            default: begin
                w_out_next = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_out  <= w_out_next;
            r_idx  <= w_idx_next;
            r_wrap <= w_wrap_next;
            r_busy <= w_busy_next;
        end
    end

    assign out        = r_out;
    assign active_idx = r_idx;
    assign wrap       = r_wrap;
    assign busy       = r_busy;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model.
module tb_decoder_scan;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       mode;
    logic [2:0] in_s;
    logic [7:0] dwell;
    logic [7:0] out;
    logic [2:0] active_idx;
    logic       wrap;
    logic       busy;

    logic        enable4;
    logic        mode4;
    logic [3:0]  in4;
    logic [7:0]  dwell4;
    logic [15:0] out4;
    logic [3:0]  idx4;
    logic        wrap4;
    logic        busy4;

    int n_cmp;
    int n_bad;

    // Behavioural model: tracks how many cycles the current line has been
    // shown and the hold length captured when the line was entered.
    bit         m_scan;
    int         m_idx;
    int         m_shown;
    int         m_len;
    logic [7:0] m_out;
    logic       m_wrap;
    logic       m_busy;

    decoder_scan #(
        .IN      (3),
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .in         (in_s),
        .dwell      (dwell),
        .out        (out),
        .active_idx (active_idx),
        .wrap       (wrap),
        .busy       (busy)
    );

    decoder_scan #(
        .IN      (4),
        .DWELL_W (8)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable4),
        .mode       (mode4),
        .in         (in4),
        .dwell      (dwell4),
        .out        (out4),
        .active_idx (idx4),
        .wrap       (wrap4),
        .busy       (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_scan  = 0;
        m_idx   = 0;
        m_shown = 0;
        m_len   = 0;
        m_out   = '0;
        m_wrap  = 1'b0;
        m_busy  = 1'b0;
    endtask

    // Apply one clock edge to the model using the current inputs.
    task automatic model_step();
        int d;
        d = (dwell == 0) ? 1 : int'(dwell);
        m_wrap = 1'b0;
        if (!enable) begin
            m_scan = 0;
            m_out  = '0;
            m_busy = 1'b0;
        end else if (!mode) begin
            m_scan = 0;
            m_idx  = int'(in_s);
            m_out  = 8'(1 << m_idx);
            m_busy = 1'b0;
        end else if (!m_scan) begin
            m_scan  = 1;
            m_idx   = int'(in_s);
            m_shown = 1;
            m_len   = d;
            m_out   = 8'(1 << m_idx);
            m_busy  = 1'b1;
        end else if (m_shown < m_len) begin
            m_shown = m_shown + 1;
        end else begin
            m_idx   = (m_idx + 1) % 8;
            m_shown = 1;
            m_len   = d;
            m_out   = 8'(1 << m_idx);
            m_wrap  = (m_idx == 0);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        mode    = 1'b1;
        in_s    = 3'd4;
        dwell   = 8'd3;
        enable4 = 1'b0;
        mode4   = 1'b0;
        in4     = 4'd0;
        dwell4  = 8'd0;
        #2;
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out got=%h exp=00", out); end
        n_cmp++; if (active_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", active_idx); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset_held_out got=%h exp=00", out); end
        enable = 1'b0;
        mode   = 1'b0;
        reset  = 1'b0;
        tick();
    endtask

    task automatic test_direct();
        enable = 1'b1;
        mode   = 1'b0;
        in_s   = 3'b101;
        tick();
        n_cmp++; if (out !== 8'b0010_0000) begin n_bad++; $display("FAIL direct_out got=%h exp=20", out); end
        n_cmp++; if (active_idx !== 3'd5) begin n_bad++; $display("FAIL direct_idx got=%0d exp=5", active_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL direct_busy got=%b exp=0", busy); end
        in_s = 3'd2;
        tick();
        n_cmp++; if (out !== 8'h04) begin n_bad++; $display("FAIL direct_track got=%h exp=04", out); end
        enable = 1'b0;
        tick();
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL direct_disable_out got=%h exp=00", out); end
        n_cmp++; if (active_idx !== 3'd2) begin n_bad++; $display("FAIL idle_idx_hold got=%0d exp=2", active_idx); end
    endtask

    task automatic test_scan_dwell2();
        logic [7:0] exp_out [7];
        logic       exp_wrap [7];
        exp_out  = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        in_s   = 3'd6;
        dwell  = 8'd2;
        mode   = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            n_cmp++; if (out !== exp_out[k]) begin n_bad++; $display("FAIL scan2_out[%0d] got=%h exp=%h", k, out, exp_out[k]); end
            n_cmp++; if (wrap !== exp_wrap[k]) begin n_bad++; $display("FAIL scan2_wrap[%0d] got=%b exp=%b", k, wrap, exp_wrap[k]); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL scan2_busy[%0d] got=%b exp=1", k, busy); end
        end
        enable = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL scan2_exit_busy got=%b exp=0", busy); end
    endtask

    task automatic test_dwell0();
        logic [7:0] e_out;
        logic       e_wrap;
        in_s   = 3'd0;
        dwell  = 8'd0;
        mode   = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            e_out  = 8'(1 << (k % 8));
            e_wrap = (k > 0) && (k % 8 == 0);
            n_cmp++; if (out !== e_out) begin n_bad++; $display("FAIL dwell0_out[%0d] got=%h exp=%h", k, out, e_out); end
            n_cmp++; if (wrap !== e_wrap) begin n_bad++; $display("FAIL dwell0_wrap[%0d] got=%b exp=%b", k, wrap, e_wrap); end
            n_cmp++; if (active_idx !== 3'(k % 8)) begin n_bad++; $display("FAIL dwell0_idx[%0d] got=%0d exp=%0d", k, active_idx, k % 8); end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_mid_exit();
        logic [7:0] e_out;
        in_s   = 3'd1;
        dwell  = 8'd5;
        mode   = 1'b1;
        enable = 1'b1;
        tick();
        n_cmp++; if (out !== 8'h02) begin n_bad++; $display("FAIL mid_entry_out got=%h exp=02", out); end
        tick();
        tick();
        mode = 1'b0;
        in_s = 3'd2;
        tick();
        n_cmp++; if (out !== 8'h04) begin n_bad++; $display("FAIL mid_direct_out got=%h exp=04", out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_direct_busy got=%b exp=0", busy); end
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            e_out = (k < 5) ? 8'h04 : 8'h08;
            n_cmp++; if (out !== e_out) begin n_bad++; $display("FAIL mid_reentry_out[%0d] got=%h exp=%h", k, out, e_out); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_reentry_busy[%0d] got=%b exp=1", k, busy); end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        in_s   = 3'd3;
        dwell  = 8'd4;
        mode   = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL async_out got=%h exp=00", out); end
        n_cmp++; if (active_idx !== 3'd0) begin n_bad++; $display("FAIL async_idx got=%0d exp=0", active_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy got=%b exp=0", busy); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL async_wrap got=%b exp=0", wrap); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_held_busy got=%b exp=0", busy); end
        reset = 1'b0;
        in_s  = 3'd3;
        tick();
        n_cmp++; if (out !== 8'h08) begin n_bad++; $display("FAIL async_reentry_out got=%h exp=08", out); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL async_reentry_busy got=%b exp=1", busy); end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1;
        #1;
        model_reset();
        reset  = 1'b0;
        enable = 1'b1;
        mode   = 1'b1;
        dwell  = 8'd2;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 4));
            in_s = 3'($urandom_range(0, 7));
            model_step();
            tick();
            n_cmp++; if (out !== m_out) begin n_bad++; $display("FAIL rand_out[%0d] got=%h exp=%h", c, out, m_out); end
            n_cmp++; if (active_idx !== 3'(m_idx)) begin n_bad++; $display("FAIL rand_idx[%0d] got=%0d exp=%0d", c, active_idx, m_idx); end
            n_cmp++; if (wrap !== m_wrap) begin n_bad++; $display("FAIL rand_wrap[%0d] got=%b exp=%b", c, wrap, m_wrap); end
            n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rand_busy[%0d] got=%b exp=%b", c, busy, m_busy); end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_in4();
        enable4 = 1'b1;
        mode4   = 1'b1;
        in4     = 4'd15;
        dwell4  = 8'd1;
        tick();
        n_cmp++; if (out4 !== 16'h8000) begin n_bad++; $display("FAIL in4_first_out got=%h exp=8000", out4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_bad++; $display("FAIL in4_first_wrap got=%b exp=0", wrap4); end
        tick();
        n_cmp++; if (out4 !== 16'h0001) begin n_bad++; $display("FAIL in4_wrap_out got=%h exp=0001", out4); end
        n_cmp++; if (wrap4 !== 1'b1) begin n_bad++; $display("FAIL in4_wrap got=%b exp=1", wrap4); end
        n_cmp++; if (idx4 !== 4'd0) begin n_bad++; $display("FAIL in4_idx got=%0d exp=0", idx4); end
        tick();
        n_cmp++; if (out4 !== 16'h0002) begin n_bad++; $display("FAIL in4_next_out got=%h exp=0002", out4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_bad++; $display("FAIL in4_next_wrap got=%b exp=0", wrap4); end
        enable4 = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_direct();
        test_scan_dwell2();
        test_dwell0();
        test_mid_exit();
        test_async_reset();
        test_in4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
